// File: rtl/writeback_arbiter.sv
// -----------------------------------------------------------------------------
// writeback_arbiter
// Merges register-file writes from the single-cycle ALU (port A, never stalled,
// absolute priority) and the long-latency load/multiply unit (port B, queued)
// onto the single register-file write port. Address 0 is discarded on both
// ports. A combinational hazard query reports pending writes to decode.
//
// Optional feature macro: WB_BYPASS_EN
//   defined   : an accepted B goes straight to the output register when the
//               queue is empty and A is not writing (latency 1).
//   undefined : every accepted B passes through the queue (latency >= 2).
//
// Ports:
//   iClk, iRst_n                 clock, asynchronous active-low reset
//   iValidA/iAddrA/iDataA        ALU result (no backpressure)
//   iValidB/iAddrB/iDataB        long-latency result, accepted when oReadyB
//   oReadyB                      registered port B accept
//   oEnWrite/oAddrWrite/oDataWrite  registered register-file write port
//   oCount                       queue occupancy
//   iQueryAddr/oQueryHit         decode hazard query (combinational hit)
// -----------------------------------------------------------------------------
module writeback_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          iClk,
  input  logic                          iRst_n,
  input  logic                          iValidA,
  input  logic [ADDR_WIDTH-1:0]         iAddrA,
  input  logic [DATA_WIDTH-1:0]         iDataA,
  input  logic                          iValidB,
  input  logic [ADDR_WIDTH-1:0]         iAddrB,
  input  logic [DATA_WIDTH-1:0]         iDataB,
  output logic                          oReadyB,
  output logic                          oEnWrite,
  output logic [ADDR_WIDTH-1:0]         oAddrWrite,
  output logic [DATA_WIDTH-1:0]         oDataWrite,
  output logic [$clog2(FIFO_DEPTH):0]   oCount,
  input  logic [ADDR_WIDTH-1:0]         iQueryAddr,
  output logic                          oQueryHit
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  // Queue storage and control
  logic [ADDR_WIDTH-1:0] r_mem_addr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_mem_data [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_ready_b;

  // Output register
  logic                  r_en_write;
  logic [ADDR_WIDTH-1:0] r_addr_write;
  logic [DATA_WIDTH-1:0] r_data_write;

  logic                  w_take_a;
  logic                  w_b_valid;
  logic                  w_empty;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_bypass;
  logic [CNT_W-1:0]      w_count_next;
  logic                  w_fifo_hit;

  // Request qualification; address 0 requests are consumed and dropped
  assign w_take_a  = iValidA && (iAddrA != '0);
  assign w_b_valid = iValidB && r_ready_b && (iAddrB != '0);
  assign w_empty   = (r_count == '0);
  assign w_pop     = !w_take_a && !w_empty;

`ifdef WB_BYPASS_EN
  assign w_bypass  = !w_take_a && w_empty && w_b_valid;
`else
  assign w_bypass  = 1'b0;
`endif

  assign w_push       = w_b_valid && !w_bypass;
  assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

  // Queue pointers, occupancy and registered ready
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_ready_b <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count   <= w_count_next;
      // Looks at the post-edge occupancy, so a pop on a full queue only
      // re-opens the port from the following cycle.
      r_ready_b <= (w_count_next < CNT_W'(FIFO_DEPTH));
    end
  end

  // Queue payload storage (contents are don't-care when not counted)
  always_ff @(posedge iClk) begin
    if (w_push) begin
      r_mem_addr[r_wr_ptr] <= iAddrB;
      r_mem_data[r_wr_ptr] <= iDataB;
    end
  end

  // Output register: A first, then queue head, then (optional) bypassed B
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_en_write   <= 1'b0;
      r_addr_write <= '0;
      r_data_write <= '0;
    end else if (w_take_a) begin
      r_en_write   <= 1'b1;
      r_addr_write <= iAddrA;
      r_data_write <= iDataA;
    end else if (w_pop) begin
      r_en_write   <= 1'b1;
      r_addr_write <= r_mem_addr[r_rd_ptr];
      r_data_write <= r_mem_data[r_rd_ptr];
    end else if (w_bypass) begin
      r_en_write   <= 1'b1;
      r_addr_write <= iAddrB;
      r_data_write <= iDataB;
    end else begin
      r_en_write   <= 1'b0;
    end
  end

  // Hazard scan over the occupied queue slots, oldest first
  always_comb begin
    w_fifo_hit = 1'b0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if ((CNT_W'(i) < r_count) &&
          (r_mem_addr[r_rd_ptr + PTR_W'(i)] == iQueryAddr)) begin
        w_fifo_hit = 1'b1;
      end
    end
  end

  assign oQueryHit  = (iQueryAddr != '0) &&
                      (w_fifo_hit || (r_en_write && (r_addr_write == iQueryAddr)));
  assign oReadyB    = r_ready_b;
  assign oEnWrite   = r_en_write;
  assign oAddrWrite = r_addr_write;
  assign oDataWrite = r_data_write;
  assign oCount     = r_count;

endmodule
